// File: rtl/data_mux_scheduler_if.sv
// Handshake and control bundle between the burst scheduler and its
// environment: per-input tvalid, mux output handshake, fast-control pulses,
// and the select/grant/status outputs back to the mux.
interface data_mux_scheduler_if #(
    parameter int N_INPUTS  = 2,
    parameter int CNT_WIDTH = 16
);
    logic                 enable;
    logic [CNT_WIDTH-1:0] burst_len;
    logic [N_INPUTS-1:0]  tvalid_in;
    logic                 out_tvalid;
    logic                 out_tready;
    logic                 fc_orbitSync;
    logic                 fc_linkReset;
    logic [3:0]           output_select;
    logic                 grant_valid;
    logic [N_INPUTS-1:0]  grant_onehot;
    logic                 burst_done;
    logic                 timeout_pulse;

    // Handshake: a beat is transferred on any rising clk edge where
    // out_tvalid and out_tready are both high while the scheduler is granting.

    // Environment side: drives requests and control, observes the grant.
    modport master (
        output enable, burst_len, tvalid_in, out_tvalid, out_tready,
               fc_orbitSync, fc_linkReset,
        input  output_select, grant_valid, grant_onehot, burst_done, timeout_pulse
    );

    // Scheduler side.
    modport slave (
        input  enable, burst_len, tvalid_in, out_tvalid, out_tready,
               fc_orbitSync, fc_linkReset,
        output output_select, grant_valid, grant_onehot, burst_done, timeout_pulse
    );
endinterface

// File: rtl/data_mux_scheduler.sv
// Round-robin burst scheduler driving the AXIS data mux select. Grants one
// input for up to burst_len accepted beats, rotates, releases a stalled input
// after TIMEOUT_CYCLES idle cycles, and honours linkReset / orbitSync.
module data_mux_scheduler #(
    parameter int N_INPUTS       = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mux_scheduler_if.slave   bus,
    output logic [1:0]            o_dbg_state
);
    localparam int PW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t               r_state, w_state_n;
    logic [PW-1:0]        r_ptr, w_ptr_n;
    logic [PW-1:0]        r_sel, w_sel_n;
    logic [CNT_WIDTH-1:0] r_len, w_len_n;
    logic [CNT_WIDTH-1:0] r_beat_cnt, w_beat_n;
    logic [IW-1:0]        r_idle_cnt, w_idle_n;
    logic                 r_pend, w_pend_n;
    logic                 r_grant_valid;
    logic [N_INPUTS-1:0]  r_onehot, w_onehot_n;
    logic                 r_done, w_done_n;
    logic                 r_tmo, w_tmo_n;

    logic                 w_found;
    logic [PW-1:0]        w_pick;
    logic [PW-1:0]        w_cand;
    logic                 w_beat;
    logic                 w_pend_any;
    logic [PW-1:0]        w_exit_ptr;
    logic [CNT_WIDTH-1:0] w_len_eff;

    assign w_beat     = bus.out_tvalid & bus.out_tready;
    assign w_pend_any = r_pend | bus.fc_orbitSync;
    // A pending orbitSync makes the next rotation restart at input 0.
    assign w_exit_ptr = w_pend_any ? PW'(N_INPUTS - 1) : r_sel;
    assign w_len_eff  = (bus.burst_len == '0) ? CNT_WIDTH'(1) : bus.burst_len;

    // Round-robin search: scan from farthest to nearest so the input closest
    // after r_ptr is the one left in w_pick.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = N_INPUTS; k >= 1; k--) begin
            w_cand = PW'((int'(r_ptr) + k) % N_INPUTS);
            if (bus.tvalid_in[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state and next-output logic; linkReset overrides everything else.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_sel_n   = r_sel;
        w_len_n   = r_len;
        w_beat_n  = r_beat_cnt;
        w_idle_n  = r_idle_cnt;
        w_pend_n  = w_pend_any;
        w_done_n  = 1'b0;
        w_tmo_n   = 1'b0;
        if (bus.fc_linkReset) begin
            w_state_n = S_ARB;
            w_ptr_n   = PW'(N_INPUTS - 1);
            w_pend_n  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        w_state_n = S_ARB;
                        if (w_pend_any) w_ptr_n = PW'(N_INPUTS - 1);
                        w_pend_n  = 1'b0;
                    end
                end
                S_ARB: begin
                    if (!bus.enable) begin
                        w_state_n = S_IDLE;
                    end else if (w_found) begin
                        w_state_n = S_GRANT;
                        w_sel_n   = w_pick;
                        w_len_n   = w_len_eff;
                        w_beat_n  = '0;
                        w_idle_n  = '0;
                    end
                end
                S_GRANT: begin
                    if (w_beat && (r_beat_cnt == r_len - CNT_WIDTH'(1))) begin
                        // Completion wins over a simultaneous timeout.
                        w_done_n  = 1'b1;
                        w_ptr_n   = w_exit_ptr;
                        w_pend_n  = 1'b0;
                        w_state_n = bus.enable ? S_ARB : S_IDLE;
                    end else begin
                        if (w_beat) w_beat_n = r_beat_cnt + CNT_WIDTH'(1);
                        if (!bus.tvalid_in[r_sel]) begin
                            if (r_idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                                w_tmo_n   = 1'b1;
                                w_ptr_n   = w_exit_ptr;
                                w_pend_n  = 1'b0;
                                w_state_n = S_ARB;
                            end else begin
                                w_idle_n = r_idle_cnt + IW'(1);
                            end
                        end else begin
                            w_idle_n = '0;
                        end
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
        w_onehot_n = (w_state_n == S_GRANT) ? (N_INPUTS'(1) << w_sel_n) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= PW'(N_INPUTS - 1);
            r_sel         <= '0;
            r_len         <= '0;
            r_beat_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_pend        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_onehot      <= '0;
            r_done        <= 1'b0;
            r_tmo         <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ptr         <= w_ptr_n;
            r_sel         <= w_sel_n;
            r_len         <= w_len_n;
            r_beat_cnt    <= w_beat_n;
            r_idle_cnt    <= w_idle_n;
            r_pend        <= w_pend_n;
            r_grant_valid <= (w_state_n == S_GRANT);
            r_onehot      <= w_onehot_n;
            r_done        <= w_done_n;
            r_tmo         <= w_tmo_n;
        end
    end

    assign bus.output_select = 4'(r_sel);
    assign bus.grant_valid   = r_grant_valid;
    assign bus.grant_onehot  = r_onehot;
    assign bus.burst_done    = r_done;
    assign bus.timeout_pulse = r_tmo;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_data_mux_scheduler.sv
// Bench for data_mux_scheduler: directed scenarios plus random traffic,
// with a transaction-level reference model feeding an expected-event queue
// that a separate monitor drains against what the DUT emits.
module tb_data_mux_scheduler;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int CW  = 8;
    localparam int W   = 28;

    localparam int EV_GRANT = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_TMO   = 3;
    localparam int EV_ABORT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    data_mux_scheduler_if #(.N_INPUTS(N), .CNT_WIDTH(CW)) bus ();

    data_mux_scheduler #(
        .N_INPUTS(N), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model: phase 0 idle, 1 arbitrating, 2 granted.
    int m_phase = 0;
    int m_sel = 0;
    int m_len = 0;
    int m_beats = 0;
    int m_idle = 0;
    int m_ptr = N - 1;
    bit m_pend = 1'b0;

    function automatic void push_ev(input int typ, input int sel);
        exp_q.push_back({20'(edge_n + 1), 4'(typ), 4'(sel)});
    endfunction

    function automatic void model_step(input logic [N-1:0] tv, input bit otv, input bit otr,
                                       input bit en, input int len, input bit os,
                                       input bit lr, input bit rst);
        bit pend_any;
        bit found;
        int pick;
        if (rst) begin
            if (m_phase == 2) push_ev(EV_ABORT, 0);
            m_phase = 0; m_sel = 0; m_len = 0; m_beats = 0; m_idle = 0;
            m_ptr = N - 1; m_pend = 1'b0;
            return;
        end
        if (lr) begin
            if (m_phase == 2) push_ev(EV_ABORT, m_sel);
            m_phase = 1; m_ptr = N - 1; m_pend = 1'b0;
            return;
        end
        pend_any = m_pend | os;
        m_pend = pend_any;
        case (m_phase)
            0: begin
                if (en) begin
                    m_phase = 1;
                    if (pend_any) m_ptr = N - 1;
                    m_pend = 1'b0;
                end
            end
            1: begin
                if (!en) begin
                    m_phase = 0;
                end else begin
                    found = 1'b0;
                    pick = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && tv[(m_ptr + k) % N]) begin
                            found = 1'b1;
                            pick = (m_ptr + k) % N;
                        end
                    end
                    if (found) begin
                        m_phase = 2; m_sel = pick;
                        m_len = (len == 0) ? 1 : len;
                        m_beats = 0; m_idle = 0;
                        push_ev(EV_GRANT, pick);
                    end
                end
            end
            default: begin
                if (otv && otr) m_beats++;
                if (otv && otr && m_beats == m_len) begin
                    push_ev(EV_DONE, m_sel);
                    m_ptr = pend_any ? N - 1 : m_sel;
                    m_pend = 1'b0;
                    m_phase = en ? 1 : 0;
                end else if (!tv[m_sel]) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        push_ev(EV_TMO, m_sel);
                        m_ptr = pend_any ? N - 1 : m_sel;
                        m_pend = 1'b0;
                        m_phase = 1;
                    end
                end else begin
                    m_idle = 0;
                end
            end
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic [N-1:0] tv, input bit otv, input bit otr, input bit en,
                         input int len, input bit os, input bit lr, input bit rst);
        @(posedge clk);
        #1;
        bus.tvalid_in    = tv;
        bus.out_tvalid   = otv;
        bus.out_tready   = otr;
        bus.enable       = en;
        bus.burst_len    = CW'(len);
        bus.fc_orbitSync = os;
        bus.fc_linkReset = lr;
        reset            = rst;
        model_step(tv, otv, otr, en, len, os, lr, rst);
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, want);
        end
    endtask

    // ---------------- monitor ----------------
    int cur_sel = 0;
    bit prev_gv = 1'b0;

    task automatic observe(input int typ);
        logic [W-1:0] got;
        logic [W-1:0] want;
        total++;
        got = {20'(edge_n), 4'(typ), bus.output_select};
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            if (got != want) begin
                bad++;
                $display("FAIL event: got=%h want=%h", got, want);
            end
            if (want[7:4] == 4'(EV_GRANT)) cur_sel = int'(want[3:0]);
        end
    endtask

    initial begin
        logic [W-1:0] lost;
        forever begin
            @(posedge clk);
            edge_n++;
            #2;
            while (exp_q.size() > 0 && exp_q[0][27:8] < 20'(edge_n)) begin
                lost = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL event_missing: got=none want=%h", lost);
            end
            if (bus.grant_valid && !prev_gv) observe(EV_GRANT);
            if (bus.burst_done) observe(EV_DONE);
            if (bus.timeout_pulse) observe(EV_TMO);
            if (prev_gv && !bus.grant_valid && !bus.burst_done && !bus.timeout_pulse)
                observe(EV_ABORT);
            if (bus.grant_valid) begin
                chk("select", int'(bus.output_select), cur_sel);
                chk("onehot", int'(bus.grant_onehot), 1 << cur_sel);
            end else begin
                chk("onehot_idle", int'(bus.grant_onehot), 0);
            end
            prev_gv = bus.grant_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit hit;
        logic [N-1:0] tvr;
        reset = 1'b1;
        bus.tvalid_in = '0; bus.out_tvalid = 1'b0; bus.out_tready = 1'b0;
        bus.enable = 1'b0; bus.burst_len = '0;
        bus.fc_orbitSync = 1'b0; bus.fc_linkReset = 1'b0;

        repeat (3) cycle('0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("rst_grant_valid", int'(bus.grant_valid), 0);
        chk("rst_onehot", int'(bus.grant_onehot), 0);
        chk("rst_select", int'(bus.output_select), 0);
        chk("rst_burst_done", int'(bus.burst_done), 0);
        chk("rst_timeout", int'(bus.timeout_pulse), 0);
        chk("rst_state", int'(dbg_state), 0);

        // Alternating 4-beat bursts between inputs 0 and 1.
        repeat (40) cycle(4'b0011, 1, 1, 1, 4, 0, 0, 0);
        // Zero length behaves as single-beat bursts.
        repeat (20) cycle(4'b0011, 1, 1, 1, 0, 0, 0, 0);

        // Granted input goes quiet: forced release after TMO idle cycles.
        repeat (6) cycle(4'b0011, 1, 1, 1, 100, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            tvr = (m_phase == 2) ? (4'b0011 & ~(4'(1) << m_sel)) : 4'b0011;
            cycle(tvr, 1, 1, 1, 100, 0, 0, 0);
        end

        // linkReset at beat 2 of input 1.
        hit = 1'b0;
        for (int g = 0; g < 400 && !hit; g++) begin
            if (m_phase == 2 && m_sel == 1 && m_beats == 2) begin
                cycle(4'b0011, 1, 1, 1, 6, 0, 1, 0);
                hit = 1'b1;
            end else begin
                cycle(4'b0011, 1, 1, 1, 6, 0, 0, 0);
            end
        end
        chk("linkreset_reached", int'(hit), 1);
        repeat (12) cycle(4'b0011, 1, 1, 1, 6, 0, 0, 0);

        // orbitSync during input 2's burst: rotation restarts at input 0.
        hit = 1'b0;
        for (int g = 0; g < 400 && !hit; g++) begin
            if (m_phase == 2 && m_sel == 2) begin
                cycle(4'b1111, 1, 1, 1, 3, 1, 0, 0);
                hit = 1'b1;
            end else begin
                cycle(4'b1111, 1, 1, 1, 3, 0, 0, 0);
            end
        end
        chk("orbitsync_reached", int'(hit), 1);
        repeat (20) cycle(4'b1111, 1, 1, 1, 3, 0, 0, 0);

        // Back-pressure for 20 cycles mid-burst: no timeout, burst resumes.
        hit = 1'b0;
        for (int g = 0; g < 400 && !hit; g++) begin
            cycle(4'b1111, 1, 1, 1, 8, 0, 0, 0);
            if (m_phase == 2 && m_beats == 3) hit = 1'b1;
        end
        chk("stall_reached", int'(hit), 1);
        repeat (20) cycle(4'b1111, 1, 0, 1, 8, 0, 0, 0);
        repeat (30) cycle(4'b1111, 1, 1, 1, 8, 0, 0, 0);

        // Random traffic with occasional control pulses and resets.
        tvr = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) tvr = 4'($urandom_range(0, 15));
            cycle(tvr,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) != 0,
                  int'($urandom_range(0, 5)),
                  $urandom_range(0, 63) == 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 299) == 0);
        end

        repeat (6) cycle('0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
